// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM encoding, line geometry and tag-width helper for the data cache.
package dcache_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

    localparam int OFFSET_BITS = 2;
    localparam int LINE_BYTES  = 4;

    function automatic int tag_width(input int addr_w, input int index_bits);
        return addr_w - index_bits - OFFSET_BITS;
    endfunction
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage of the direct-mapped cache.
// One shared index serves the combinational read, the byte write and the line fill.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_W      = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [INDEX_BITS-1:0]   idx_i,
    input  logic                    byte_we_i,
    input  logic [OFFSET_BITS-1:0]  byte_off_i,
    input  logic [7:0]              byte_i,
    input  logic                    fill_i,
    input  logic [TAG_W-1:0]        fill_tag_i,
    input  logic [8*LINE_BYTES-1:0] fill_line_i,
    output logic                    valid_o,
    output logic                    dirty_o,
    output logic [TAG_W-1:0]        tag_o,
    output logic [8*LINE_BYTES-1:0] line_o
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]        valid_q, dirty_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [8*LINE_BYTES-1:0] data_q [LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data storage survive reset; only the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (byte_we_i) begin
            data_q[idx_i][{byte_off_i, 3'b000} +: 8] <= byte_i;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back/write-allocate data cache between CPU and word memory.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INDEX_BITS = 3
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        READ,
    input  logic                        WRITE,
    input  logic [ADDR_W-1:0]           ADDRESS,
    input  logic [7:0]                  WRITEDATA,
    output logic [7:0]                  READDATA,
    output logic                        BUSYWAIT,
    output logic                        MEM_READ,
    output logic                        MEM_WRITE,
    output logic [ADDR_W-OFFSET_BITS-1:0] MEM_ADDRESS,
    output logic [8*LINE_BYTES-1:0]     MEM_WRITEDATA,
    input  logic [8*LINE_BYTES-1:0]     MEM_READDATA,
    input  logic                        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                 HIT_COUNT,
    output logic [15:0]                 MISS_COUNT
`endif
);
    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

    state_e                  state_q;
    logic [INDEX_BITS-1:0]   idx_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    mem_read_q, mem_write_q;
    logic [ADDR_W-OFFSET_BITS-1:0] mem_addr_q;
    logic [8*LINE_BYTES-1:0] wdata_q;

    logic [TAG_W-1:0]        a_tag, l_tag;
    logic [INDEX_BITS-1:0]   a_idx, arr_idx;
    logic [OFFSET_BITS-1:0]  a_off;
    logic                    idle, req, hit, l_valid, l_dirty;
    logic [8*LINE_BYTES-1:0] l_line;

    assign a_tag   = ADDRESS[ADDR_W-1 -: TAG_W];
    assign a_idx   = ADDRESS[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign a_off   = ADDRESS[OFFSET_BITS-1:0];
    assign idle    = state_q == IDLE;
    assign req     = READ | WRITE;
    assign arr_idx = idle ? a_idx : idx_q;
    assign hit     = idle && l_valid && l_tag == a_tag;

    assign READDATA      = (hit && READ && !WRITE) ? l_line[{a_off, 3'b000} +: 8] : 8'h00;
    assign BUSYWAIT      = RESET && (!idle || (req && !hit));
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = wdata_q;

    dcache_line_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .idx_i      (arr_idx),
        .byte_we_i  (hit && WRITE),
        .byte_off_i (a_off),
        .byte_i     (WRITEDATA),
        .fill_i     (state_q == FETCH && !MEM_BUSYWAIT),
        .fill_tag_i (tag_q),
        .fill_line_i(MEM_READDATA),
        .valid_o    (l_valid),
        .dirty_o    (l_dirty),
        .tag_o      (l_tag),
        .line_o     (l_line)
    );

    // Index/tag are captured at miss entry so the fill ignores any later ADDRESS change.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tag_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (req && !hit) begin
                    idx_q <= a_idx;
                    tag_q <= a_tag;
                    if (l_valid && l_dirty) begin
                        state_q     <= WRITEBACK;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {l_tag, a_idx};
                        wdata_q     <= l_line;
                    end else begin
                        state_q    <= FETCH;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= {a_tag, a_idx};
                    end
                end
                WRITEBACK: if (!MEM_BUSYWAIT) begin
                    state_q     <= FETCH;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b1;
                    mem_addr_q  <= {tag_q, idx_q};
                    wdata_q     <= '0;
                end
                FETCH: if (!MEM_BUSYWAIT) begin
                    state_q    <= IDLE;
                    mem_read_q <= 1'b0;
                    mem_addr_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (req && hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (idle && req && !hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed stimulus plus a flat-memory model of what the CPU must observe.
module tb_dcache_responder;
    localparam int LAT = 5;

    logic        CLK = 1'b0, RESET = 1'b0, READ = 1'b0, WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00, WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

    int vectors = 0, errors = 0;

    always #5 CLK = ~CLK;

    dcache_responder #(.ADDR_W(8), .INDEX_BITS(3)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slow word memory: each request is busy for LAT-1 cycles and completes on the LAT-th.
    logic [31:0] mem_words [64];
    int cnt = 0;
    assign MEM_READDATA = mem_words[MEM_ADDRESS];
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && cnt < LAT - 1;

    always @(posedge CLK) begin
        if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
            if (MEM_WRITE) mem_words[MEM_ADDRESS] <= MEM_WRITEDATA;
            cnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    // Model: the CPU sees a flat byte memory; the cache directory decides stalls and bus traffic.
    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } xact_t;

    logic [7:0] view [256];
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [2:0] m_tag [8];
    xact_t      pend[$];

    function automatic logic [31:0] view_line(input logic [5:0] blk);
        return {view[{blk, 2'd3}], view[{blk, 2'd2}], view[{blk, 2'd1}], view[{blk, 2'd0}]};
    endfunction

    always @(negedge CLK) begin
        logic [7:0] a;
        logic [2:0] idx, tg;
        xact_t      x;
        a   = ADDRESS;
        idx = a[4:2];
        tg  = a[7:5];
        if (!RESET) begin
            check("rst_busywait", BUSYWAIT, 0);
            check("rst_mem_read", MEM_READ, 0);
            check("rst_mem_write", MEM_WRITE, 0);
            check("rst_readdata", READDATA, 0);
            check("rst_mem_addr", MEM_ADDRESS, 0);
            check("rst_mem_wdata", MEM_WRITEDATA, 0);
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            pend.delete();
            for (int i = 0; i < 256; i++) view[i] = mem_words[i >> 2][8*(i % 4) +: 8];
        end else if (pend.size() != 0) begin
            x = pend[0];
            check("miss_busywait", BUSYWAIT, 1);
            check("bus_mem_write", MEM_WRITE, x.wr);
            check("bus_mem_read", MEM_READ, !x.wr);
            check("bus_mem_addr", MEM_ADDRESS, x.addr);
            if (x.wr) check("bus_mem_wdata", MEM_WRITEDATA, x.data);
            if (!MEM_BUSYWAIT) begin
                if (!x.wr) begin
                    m_valid[x.addr[2:0]] = 1'b1;
                    m_dirty[x.addr[2:0]] = 1'b0;
                    m_tag[x.addr[2:0]]   = x.addr[5:3];
                end
                void'(pend.pop_front());
            end
        end else begin
            check("idle_mem_read", MEM_READ, 0);
            check("idle_mem_write", MEM_WRITE, 0);
            if (READ || WRITE) begin
                if (m_valid[idx] && m_tag[idx] == tg) begin
                    check("hit_busywait", BUSYWAIT, 0);
                    check("hit_readdata", READDATA, (READ && !WRITE) ? view[a] : 8'h00);
                    if (WRITE) begin
                        view[a]      = WRITEDATA;
                        m_dirty[idx] = 1'b1;
                    end
                end else begin
                    check("miss_busywait", BUSYWAIT, 1);
                    check("miss_readdata", READDATA, 0);
                    if (m_valid[idx] && m_dirty[idx])
                        pend.push_back('{1'b1, {m_tag[idx], idx}, view_line({m_tag[idx], idx})});
                    pend.push_back('{1'b0, {tg, idx}, 32'h0});
                end
            end else begin
                check("noreq_busywait", BUSYWAIT, 0);
                check("noreq_readdata", READDATA, 0);
            end
        end
    end

    int          stall, n_wr, n_rd;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic        order_ok, both_hi;
    logic [7:0]  rd_val;

    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
        stall = 0; n_wr = 0; n_rd = 0; order_ok = 1'b1; both_hi = 1'b0;
        forever begin
            @(negedge CLK);
            if (MEM_WRITE) begin
                if (n_rd > 0) order_ok = 1'b0;
                if (n_wr == 0) begin
                    wr_addr = MEM_ADDRESS;
                    wr_data = MEM_WRITEDATA;
                end
                n_wr++;
            end
            if (MEM_READ) begin
                if (n_rd == 0) rd_addr = MEM_ADDRESS;
                n_rd++;
            end
            if (MEM_READ && MEM_WRITE) both_hi = 1'b1;
            if (!BUSYWAIT) break;
            stall++;
            if (stall > 100) begin
                check("access_timeout", stall, 0);
                break;
            end
        end
        rd_val = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic miss_drop(input logic [7:0] a);
        @(posedge CLK); #1;
        READ = 1'b1; WRITE = 1'b0; ADDRESS = a;
        stall = 0; n_rd = 0;
        forever begin
            @(negedge CLK);
            if (MEM_READ) begin
                if (n_rd == 0) rd_addr = MEM_ADDRESS;
                n_rd++;
            end
            if (!BUSYWAIT) break;
            stall++;
            if (stall == 1) begin
                @(posedge CLK); #1;
                READ = 1'b0;
            end
            if (stall > 100) begin
                check("drop_timeout", stall, 0);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem_words[i] = 32'h10203040 + i * 32'h01010101;
        mem_words[1] = 32'hDDCCBBAA;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        access(1, 0, 8'h05, 8'h00);
        check("cold_stall", stall, 6);
        check("cold_rd_addr", rd_addr, 6'h01);
        check("cold_no_wb", n_wr, 0);
        check("cold_data", rd_val, 8'hBB);

        access(0, 1, 8'h05, 8'h7E);
        check("whit_stall", stall, 0);
        access(1, 0, 8'h05, 8'h00);
        check("whit_readback", rd_val, 8'h7E);

        access(1, 0, 8'h25, 8'h00);
        check("evict_stall", stall, 11);
        check("evict_wr_addr", wr_addr, 6'h01);
        check("evict_wr_data", wr_data, 32'hDDCC7EAA);
        check("evict_rd_addr", rd_addr, 6'h09);
        check("evict_order", order_ok, 1);
        check("evict_both_high", both_hi, 0);
        check("evict_data", rd_val, 8'h39);

        access(1, 0, 8'h05, 8'h00);
        check("clean_no_wb", n_wr, 0);
        check("clean_rd_addr", rd_addr, 6'h01);
        check("clean_stall", stall, 6);
        check("clean_data", rd_val, 8'h7E);

        access(1, 1, 8'h05, 8'h3C);
        check("rw_stall", stall, 0);
        access(1, 0, 8'h05, 8'h00);
        check("rw_readback", rd_val, 8'h3C);
        access(1, 0, 8'h25, 8'h00);
        check("rw_dirty_wb_count", n_wr, 5);
        check("rw_dirty_wb_data", wr_data, 32'hDDCC3CAA);

        @(posedge CLK); #1;
        READ = 1'b1; ADDRESS = 8'h10;
        repeat (3) @(negedge CLK);
        check("pre_rst_mem_read", MEM_READ, 1);
        #1 RESET = 1'b0;
        #1;
        check("async_rst_mem_read", MEM_READ, 0);
        check("async_rst_busywait", BUSYWAIT, 0);
        READ = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        miss_drop(8'h05);
        check("post_rst_stall", stall, 6);
        check("post_rst_rd_addr", rd_addr, 6'h01);
        access(1, 0, 8'h05, 8'h00);
        check("post_rst_data", rd_val, 8'h3C);
        check("post_rst_hit", stall, 0);
        access(1, 0, 8'h06, 8'h00);
        check("hit2_data", rd_val, 8'hCC);
        access(0, 1, 8'h07, 8'h55);
        check("hit3_stall", stall, 0);
        miss_drop(8'h30);
        check("miss2_stall", stall, 6);
        check("miss2_rd_addr", rd_addr, 6'h0C);
`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        check("stats_hits", HIT_COUNT, 16'd3);
        check("stats_misses", MISS_COUNT, 16'd2);
`endif
        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
